node_exec: RTL and testbench
============================

Name: node_exec

Overview:
- Execute stage of a TIS-100 node; sits directly upstream of the node's acc/bak register block.
- Takes one decoded instruction per `start` and fetches its source operand. The operand comes from an immediate, ACC, NIL, or one of four neighbour ports; port reads use a blocking valid/ready handshake.
- Computes the saturated ALU result and issues exactly one register command (`reg_instr`/`reg_val`) to the register block, then pulses `done` to the sequencer.

Parameters:
- DATA_W, 11, signed datapath width.
- SAT_MAX, 999, symmetric saturation bound; results are clamped to [-SAT_MAX, +SAT_MAX].
- NUM_PORTS, 4, neighbour ports: 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  node step enable; all state advances only on clk edges with clk_en=1.
- start  in  1  instruction valid; sampled only in IDLE.
- op  in  3  0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 NEG, 5 SWP, 6 SAV, 7 reserved (treated as NOP).
- src  in  3  0 IMM, 1 ACC, 2 NIL, 3 reserved (treated as NIL), 4..7 PORT0..PORT3.
- imm  in  DATA_W  signed immediate.
- acc_in  in  DATA_W  current ACC from the register block.
- port_data  in  NUM_PORTS*DATA_W  port k occupies bits [k*DATA_W +: DATA_W].
- port_valid  in  NUM_PORTS  neighbour has data.
- port_ready  out  NUM_PORTS  this node is reading port k.
- reg_instr  out  2  INSTR_REG_* command to the register block.
- reg_val  out  DATA_W  write value to the register block.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- **Reset (async, immediate):**
  - state=IDLE.
  - port_ready=0, reg_instr=INSTR_REG_NOP, reg_val=0, done=0, busy=0.
  - Reset mid-FETCH drops port_ready without completing the transfer; nothing is issued.
- **FSM states:** IDLE, FETCH, ISSUE. All outputs are registered.
- **IDLE:**
  - On a clk_en edge with start=1, latch op, src and imm.
  - If op is MOV/ADD/SUB and src is a port → FETCH, with port_ready[src-4]=1 from the next cycle.
  - Otherwise → ISSUE.
  - start=0 → stay in IDLE.
- **FETCH:**
  - Hold the single selected port_ready bit high.
  - On a clk_en edge with port_valid&port_ready for that port: capture port_data, drop port_ready, → ISSUE.
  - Wait indefinitely otherwise; port_valid on other ports is ignored.
- **ISSUE:**
  - Lasts exactly one cycle. reg_instr/reg_val are non-NOP and done=1 only in this state.
  - On the next clk_en edge: → IDLE, reg_instr=NOP, done=0.
- **Operand value:**
  - IMM = imm; ACC = acc_in; NIL = 0; PORT = captured data.
- **Result:**
  - Computed at the edge entering ISSUE, in DATA_W+1 signed bits, then clamped to ±SAT_MAX.
  - MOV: operand. ADD: acc_in+operand. SUB: acc_in−operand. NEG: −acc_in.
  - MOV, ADD, SUB and NEG issue INSTR_REG_WRITE with reg_val = the clamped result.
  - SWP issues INSTR_REG_SWP, SAV issues INSTR_REG_SAV, NOP/reserved issues INSTR_REG_NOP; reg_val=0 for all four.
  - done still pulses for NOP.
- **Latency (clk_en edges):**
  - Non-port instruction: start edge → ISSUE one edge later.
  - Port instruction: 1 edge to assert ready, then handshake edge → ISSUE.
- **Edge rules:**
  - clk_en=0 freezes state and all outputs; a ready/valid overlap counts only on a clk_en edge.
  - start while busy is ignored.
  - acc_in is stable through the instruction, since only this block commands ACC writes.

Decomposition:
- Add to my_params.vh: OP_* (op codes), SRC_* (source codes) and SAT_MAX. Reuse the existing INSTR_REG_NOP/WRITE/SWP/SAV.
- One natural sub-module, `alu_sat`: combinational op/acc/operand → clamped DATA_W result.

Test Plan:
- Reset/idle check: assert reset mid-cycle → outputs reset immediately. Then start MOV IMM imm=42 → one cycle later: reg_instr=WRITE, reg_val=42, done=1 for one cycle, then NOP.
- ADD saturation: acc_in=900, ADD IMM 500 → reg_val=999. SUB IMM 500 with acc_in=-900 → reg_val=-999. NEG with acc_in=-999 → 999.
- Blocking port read: ADD PORT2 with acc_in=10.
  - Hold port_valid[2]=0 for 5 cycles → port_ready=4'b0100, busy=1, no done.
  - Then port_data[2]=7, valid=1 → next cycle reg_val=17, port_ready=0.
  - Other ports' valid is ignored throughout.
- SWP/SAV/NOP: each issues the matching INSTR_REG_* with reg_val=0 and one done pulse. op=7 → NOP with done. start pulsed during ISSUE → ignored.
- clk_en gating: toggle clk_en 1/0 during a port FETCH → state and outputs hold on every disabled edge; the transfer happens only on an enabled edge.
- Reset during FETCH (port_ready=1) → port_ready=0 asynchronously, no WRITE issued, FSM returns to IDLE and accepts the next start.

Source files
------------

// File: rtl/node_exec_pkg.sv
// node_exec_pkg: shared widths, op/src codes, register-block commands and FSM states for node_exec
package node_exec_pkg;
  localparam int DATA_W = 11;
  localparam int SAT_MAX = 999;
  localparam int NUM_PORTS = 4;
  typedef enum logic [2:0] {OP_NOP, OP_MOV, OP_ADD, OP_SUB, OP_NEG, OP_SWP, OP_SAV, OP_RSV} op_e;
  localparam logic [2:0] SRC_IMM = 3'd0;
  localparam logic [2:0] SRC_ACC = 3'd1;
  localparam logic [2:0] SRC_NIL = 3'd2;
  localparam logic [2:0] SRC_PORT0 = 3'd4;
  typedef enum logic [1:0] {INSTR_REG_NOP, INSTR_REG_WRITE, INSTR_REG_SWP, INSTR_REG_SAV} instr_e;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE} state_e;
endpackage

// File: rtl/alu_sat.sv
// alu_sat: op_i/acc_i/opnd_i -> instr_o register command and val_o result clamped to +-SAT_MAX
module alu_sat
  import node_exec_pkg::*;
(
  input  logic [2:0]               op_i,
  input  logic signed [DATA_W-1:0] acc_i,
  input  logic signed [DATA_W-1:0] opnd_i,
  output logic [1:0]               instr_o,
  output logic signed [DATA_W-1:0] val_o
);
  localparam logic signed [DATA_W:0] MAXV = SAT_MAX;
  logic signed [DATA_W:0] a, b, sum, clamp;
  logic is_w;
  assign a = {acc_i[DATA_W-1], acc_i};
  assign b = {opnd_i[DATA_W-1], opnd_i};
  assign is_w = op_i inside {OP_MOV, OP_ADD, OP_SUB, OP_NEG};
  assign sum = op_i == OP_MOV ? b : op_i == OP_ADD ? a + b : op_i == OP_SUB ? a - b : -a;
  assign clamp = sum > MAXV ? MAXV : sum < -MAXV ? -MAXV : sum;
  assign val_o = is_w ? clamp[DATA_W-1:0] : '0;
  assign instr_o = is_w ? INSTR_REG_WRITE : op_i == OP_SWP ? INSTR_REG_SWP :
                   op_i == OP_SAV ? INSTR_REG_SAV : INSTR_REG_NOP;
endmodule

// File: rtl/node_exec.sv
// node_exec: TIS-100 execute stage; start/op/src/imm in, operand from imm/acc_in/nil/port_data via port_valid/port_ready, one reg_instr/reg_val command plus done out, busy while not idle
module node_exec
  import node_exec_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic                          start,
  input  logic [2:0]                    op,
  input  logic [2:0]                    src,
  input  logic signed [DATA_W-1:0]      imm,
  input  logic signed [DATA_W-1:0]      acc_in,
  input  logic [NUM_PORTS*DATA_W-1:0]   port_data,
  input  logic [NUM_PORTS-1:0]          port_valid,
  output logic [NUM_PORTS-1:0]          port_ready,
  output logic [1:0]                    reg_instr,
  output logic signed [DATA_W-1:0]      reg_val,
  output logic                          busy,
  output logic                          done
);
  state_e state_q;
  logic [2:0] op_q;
  logic [$clog2(NUM_PORTS)-1:0] sel_q;
  logic [2:0] alu_op;
  logic signed [DATA_W-1:0] opnd, alu_val;
  logic [1:0] alu_instr;
  logic fetch;
  assign fetch = src >= SRC_PORT0 && (op == OP_MOV || op == OP_ADD || op == OP_SUB);
  assign alu_op = state_q == ST_IDLE ? op : op_q;
  assign opnd = state_q == ST_FETCH ? port_data[sel_q*DATA_W +: DATA_W] :
                src == SRC_IMM ? imm : src == SRC_ACC ? acc_in : '0;
  alu_sat u_alu (.op_i(alu_op), .acc_i(acc_in), .opnd_i(opnd), .instr_o(alu_instr), .val_o(alu_val));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q <= '0;
      sel_q <= '0;
      port_ready <= '0;
      reg_instr <= INSTR_REG_NOP;
      reg_val <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (clk_en) begin
      case (state_q)
        ST_IDLE: if (start) begin
          op_q <= op;
          sel_q <= src[1:0];
          busy <= 1'b1;
          if (fetch) begin
            state_q <= ST_FETCH;
            port_ready <= NUM_PORTS'(1) << src[1:0];
          end else begin
            state_q <= ST_ISSUE;
            reg_instr <= alu_instr;
            reg_val <= alu_val;
            done <= 1'b1;
          end
        end
        ST_FETCH: if (|(port_valid & port_ready)) begin
          state_q <= ST_ISSUE;
          port_ready <= '0;
          reg_instr <= alu_instr;
          reg_val <= alu_val;
          done <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          reg_instr <= INSTR_REG_NOP;
          reg_val <= '0;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_node_exec.sv
// tb_node_exec: directed self-checking bench for node_exec
module tb_node_exec;
  localparam int W = 11;
  logic clk = 1'b0, reset = 1'b1, clk_en = 1'b1, start = 1'b0;
  logic [2:0] op = '0, src = '0;
  logic signed [W-1:0] imm = '0, acc_in = '0;
  logic [4*W-1:0] port_data = '0;
  logic [3:0] port_valid = '0, port_ready;
  logic [1:0] reg_instr;
  logic signed [W-1:0] reg_val;
  logic busy, done;
  int passes = 0, total = 0;
  node_exec dut (.clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .op(op), .src(src),
    .imm(imm), .acc_in(acc_in), .port_data(port_data), .port_valid(port_valid),
    .port_ready(port_ready), .reg_instr(reg_instr), .reg_val(reg_val), .busy(busy), .done(done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [2:0] s, input int v);
    op = o;
    src = s;
    imm = W'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic out(input string tag, input int ins, input int val, input int dn, input int bz, input int rdy);
    chk({tag, ".instr"}, int'(reg_instr), ins);
    chk({tag, ".val"}, int'(reg_val), val);
    chk({tag, ".done"}, int'(done), dn);
    chk({tag, ".busy"}, int'(busy), bz);
    chk({tag, ".ready"}, int'(port_ready), rdy);
  endtask
  initial begin
    tick();
    tick();
    out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    issue(3'd1, 3'd0, 42);
    out("mov42", 1, 42, 1, 1, 0);
    tick();
    out("mov42_after", 0, 0, 0, 0, 0);
    issue(3'd1, 3'd0, 5);
    out("mov5", 1, 5, 1, 1, 0);
    #2 reset = 1'b1;
    #1 out("async_reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    acc_in = 900;
    issue(3'd2, 3'd0, 500);
    out("add_sat", 1, 999, 1, 1, 0);
    tick();
    acc_in = -900;
    issue(3'd3, 3'd0, 500);
    out("sub_sat", 1, -999, 1, 1, 0);
    tick();
    acc_in = -999;
    issue(3'd4, 3'd0, 0);
    out("neg", 1, 999, 1, 1, 0);
    tick();
    acc_in = -5;
    issue(3'd1, 3'd1, 77);
    out("mov_acc", 1, -5, 1, 1, 0);
    tick();
    issue(3'd2, 3'd3, 300);
    out("add_rsvsrc", 1, -5, 1, 1, 0);
    tick();
    acc_in = 10;
    port_data[0*W +: W] = 11'sd100;
    port_data[1*W +: W] = 11'sd200;
    port_data[3*W +: W] = 11'sd300;
    port_valid = 4'b1011;
    issue(3'd2, 3'd6, 0);
    for (int i = 0; i < 5; i++) begin
      out($sformatf("port_wait%0d", i), 0, 0, 0, 1, 4);
      tick();
    end
    port_data[2*W +: W] = 11'sd7;
    port_valid = 4'b1111;
    tick();
    port_valid = 4'b0000;
    out("port_add", 1, 17, 1, 1, 0);
    op = 3'd1;
    src = 3'd0;
    imm = 11'sd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    out("start_in_issue", 0, 0, 0, 0, 0);
    tick();
    out("start_ignored", 0, 0, 0, 0, 0);
    issue(3'd5, 3'd0, 12);
    out("swp", 2, 0, 1, 1, 0);
    tick();
    issue(3'd6, 3'd0, 12);
    out("sav", 3, 0, 1, 1, 0);
    tick();
    issue(3'd0, 3'd0, 12);
    out("nop", 0, 0, 1, 1, 0);
    tick();
    issue(3'd7, 3'd0, 12);
    out("op7", 0, 0, 1, 1, 0);
    tick();
    out("op7_after", 0, 0, 0, 0, 0);
    issue(3'd1, 3'd5, 0);
    out("gate_fetch", 0, 0, 0, 1, 2);
    port_data[1*W +: W] = -11'sd123;
    port_valid = 4'b0010;
    clk_en = 1'b0;
    tick();
    out("gate_hold0", 0, 0, 0, 1, 2);
    tick();
    out("gate_hold1", 0, 0, 0, 1, 2);
    clk_en = 1'b1;
    tick();
    port_valid = 4'b0000;
    out("gate_xfer", 1, -123, 1, 1, 0);
    clk_en = 1'b0;
    tick();
    out("gate_issue_hold", 1, -123, 1, 1, 0);
    clk_en = 1'b1;
    tick();
    out("gate_idle", 0, 0, 0, 0, 0);
    issue(3'd2, 3'd7, 0);
    out("rst_fetch", 0, 0, 0, 1, 8);
    #2 reset = 1'b1;
    #1 out("rst_fetch_async", 0, 0, 0, 0, 0);
    reset = 1'b0;
    port_data[3*W +: W] = 11'sd55;
    port_valid = 4'b1000;
    tick();
    out("rst_fetch_no_write", 0, 0, 0, 0, 0);
    port_valid = 4'b0000;
    issue(3'd1, 3'd0, 3);
    out("after_rst", 1, 3, 1, 1, 0);
    tick();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
